bcd_share_sched: RTL and testbench

Round-robin scheduler plus iterative binary-to-BCD engine, shared between several 8-bit requesters (e.g. per-oscillator frequency counters feeding one display path).
- Arbitrates requests and captures the winner's value.
- Runs one shift-and-add-3 (double-dabble) step per clock for 8 clocks.
- Presents hundreds/tens/units digits with a completion pulse tagged by requester ID.

---
 rtl/bcd_share_sched_if.sv | 25 ++
 rtl/bcd_share_sched.sv | 172 +++++++++++++++++
 tb/tb_bcd_share_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_share_sched_if.sv
// Request/result bundle between the requesters and the shared BCD scheduler.
// The master side is the requester pool; the slave side is bcd_share_sched.
interface bcd_share_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] bin_flat;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               done;
    logic [2:0]         done_id;
    logic [3:0]         cent;
    logic [3:0]         dec;
    logic [3:0]         un;

    modport master (
        output req, bin_flat,
        input  gnt, busy, done, done_id, cent, dec, un
    );

    modport slave (
        input  req, bin_flat,
        output gnt, busy, done, done_id, cent, dec, un
    );
endinterface

// File: rtl/bcd_share_sched.sv
// Round-robin scheduler feeding one iterative double-dabble engine shared by N_REQ
// 8-bit requesters; one conversion takes 8 steps and ends in a tagged done pulse.
module bcd_share_sched #(
    parameter int N_REQ = 4
) (
    input logic              clk,
    input logic              rst,
    bcd_share_sched_if.slave bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [3:0]       wCent_q, wCent_d;
    logic [3:0]       wDec_q, wDec_d;
    logic [3:0]       wUn_q, wUn_d;
    logic [2:0]       id_q, id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [2:0]       doneId_q, doneId_d;
    logic [3:0]       cent_q, cent_d;
    logic [3:0]       dec_q, dec_d;
    logic [3:0]       un_q, un_d;

    logic [7:0]  reqPad;
    logic [63:0] binPad;
    logic [3:0]  idx;
    logic [2:0]  winner;
    logic        found;
    logic [2:0]  nextPtr;

    logic [3:0]  adjCent;
    logic [3:0]  adjDec;
    logic [3:0]  adjUn;
    logic [19:0] stepVec;

    function automatic logic [3:0] addThree(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // Round-robin search starting at ptr; padding to 8 keeps indices legal for any N_REQ.
    always_comb begin
        reqPad = 8'(bus.req);
        binPad = 64'(bus.bin_flat);
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            if (!found && reqPad[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
        nextPtr = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
    end

    // One add-3 then shift over the packed {digits, shift reg}; the top bit drops out.
    always_comb begin
        adjCent = addThree(wCent_q);
        adjDec  = addThree(wDec_q);
        adjUn   = addThree(wUn_q);
        stepVec = {adjCent, adjDec, adjUn, sh_q} << 1;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        wCent_d  = wCent_q;
        wDec_d   = wDec_q;
        wUn_d    = wUn_q;
        id_d     = id_q;
        gnt_d    = '0;
        done_d   = 1'b0;
        doneId_d = doneId_q;
        cent_d   = cent_q;
        dec_d    = dec_q;
        un_d     = un_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    sh_d    = binPad[{winner, 3'b000} +: 8];
                    wCent_d = '0;
                    wDec_d  = '0;
                    wUn_d   = '0;
                    id_d    = winner;
                    gnt_d   = N_REQ'(8'd1 << winner);
                    ptr_d   = nextPtr;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                wCent_d = stepVec[19:16];
                wDec_d  = stepVec[15:12];
                wUn_d   = stepVec[11:8];
                sh_d    = stepVec[7:0];
                cnt_d   = cnt_q + 4'd1;
                // Only the finished digits reach the outputs, on the eighth step.
                if (cnt_q == 4'd7) begin
                    cent_d   = stepVec[19:16];
                    dec_d    = stepVec[15:12];
                    un_d     = stepVec[11:8];
                    done_d   = 1'b1;
                    doneId_d = id_q;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            wCent_q  <= '0;
            wDec_q   <= '0;
            wUn_q    <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            done_q   <= 1'b0;
            doneId_q <= '0;
            cent_q   <= '0;
            dec_q    <= '0;
            un_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            wCent_q  <= wCent_d;
            wDec_q   <= wDec_d;
            wUn_q    <= wUn_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            doneId_q <= doneId_d;
            cent_q   <= cent_d;
            dec_q    <= dec_d;
            un_q     <= un_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.done_id = doneId_q;
    assign bus.cent    = cent_q;
    assign bus.dec     = dec_q;
    assign bus.un      = un_q;

endmodule

// File: tb/tb_bcd_share_sched.sv
// Directed bench for bcd_share_sched: arbitration order, latency, throughput,
// input-sampling and mid-conversion reset, with hand-computed BCD results.
module tb_bcd_share_sched;

    localparam int N_REQ = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    bcd_share_sched_if #(.N_REQ(N_REQ)) busIf ();

    bcd_share_sched #(.N_REQ(N_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] reqVal);
        busIf.req = reqVal;
    endtask

    task automatic setSlice(input int k, input logic [7:0] value);
        busIf.bin_flat[8*k +: 8] = value;
    endtask

    task automatic waitGnt(input string tag, input logic [N_REQ-1:0] expGnt, output int gntCyc);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (busIf.gnt == '0 && waited < 30);
        checkOutput({tag, " gnt"}, 32'(busIf.gnt), 32'(expGnt));
        gntCyc = cyc;
    endtask

    // Called on the negedge where gnt is visible; returns on the negedge showing done.
    task automatic checkConversion(input string tag, input int expId, input int expC,
                                   input int expD, input int expU, output int doneCyc);
        int busyCnt;
        bit earlyDone;
        bit strayGnt;
        busyCnt   = busIf.busy ? 1 : 0;
        earlyDone = 1'b0;
        strayGnt  = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (busIf.busy) busyCnt++;
            if (busIf.done) earlyDone = 1'b1;
            if (busIf.gnt != '0) strayGnt = 1'b1;
        end
        checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'd8);
        checkOutput({tag, " early done"}, 32'(earlyDone), 32'd0);
        checkOutput({tag, " stray gnt"}, 32'(strayGnt), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done"}, 32'(busIf.done), 32'd1);
        checkOutput({tag, " busy after"}, 32'(busIf.busy), 32'd0);
        checkOutput({tag, " done_id"}, 32'(busIf.done_id), 32'(expId));
        checkOutput({tag, " cent"}, 32'(busIf.cent), 32'(expC));
        checkOutput({tag, " dec"}, 32'(busIf.dec), 32'(expD));
        checkOutput({tag, " un"}, 32'(busIf.un), 32'(expU));
        doneCyc = cyc;
    endtask

    initial begin
        int g1, g2, d1, prevDone;
        bit sawDone;

        rst           = 1'b1;
        busIf.req     = '0;
        busIf.bin_flat = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset gnt", 32'(busIf.gnt), 32'd0);
        checkOutput("reset busy", 32'(busIf.busy), 32'd0);
        checkOutput("reset done", 32'(busIf.done), 32'd0);
        checkOutput("reset done_id", 32'(busIf.done_id), 32'd0);
        checkOutput("reset cent", 32'(busIf.cent), 32'd0);
        checkOutput("reset dec", 32'(busIf.dec), 32'd0);
        checkOutput("reset un", 32'(busIf.un), 32'd0);
        rst = 1'b0;

        // 255 from requester 2
        setSlice(2, 8'hFF);
        applyStimulus(4'b0100);
        waitGnt("t1", 4'b0100, g1);
        applyStimulus(4'b0000);
        checkConversion("t1", 2, 2, 5, 5, d1);
        checkOutput("t1 latency", 32'(d1 - g1), 32'd8);
        @(negedge clk);
        checkOutput("t1 done pulse width", 32'(busIf.done), 32'd0);
        checkOutput("t1 hold cent", 32'(busIf.cent), 32'd2);
        checkOutput("t1 hold un", 32'(busIf.un), 32'd5);

        // Back-to-back on requester 0: value changes after capture only affect the next one
        setSlice(0, 8'd0);
        applyStimulus(4'b0001);
        waitGnt("t2a", 4'b0001, g1);
        setSlice(0, 8'd99);
        checkConversion("t2a", 0, 0, 0, 0, d1);
        waitGnt("t2b", 4'b0001, g2);
        applyStimulus(4'b0000);
        checkOutput("t2 gnt spacing", 32'(g2 - g1), 32'd9);
        checkConversion("t2b", 0, 0, 9, 9, d1);

        // All four requesting from reset: strict order 0..3
        rst = 1'b1;
        setSlice(0, 8'd10);
        setSlice(1, 8'd20);
        setSlice(2, 8'd30);
        setSlice(3, 8'd40);
        applyStimulus(4'b1111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prevDone = 0;
        for (int k = 0; k < 4; k++) begin
            waitGnt($sformatf("t3 req%0d", k), 4'(1 << k), g1);
            busIf.req[k] = 1'b0;
            checkConversion($sformatf("t3 req%0d", k), k, 0, k + 1, 0, d1);
            if (k > 0) checkOutput($sformatf("t3 done spacing %0d", k), 32'(d1 - prevDone), 32'd9);
            prevDone = d1;
        end

        // Pointer wrap: after requester 3, requester 0 wins over 3
        applyStimulus(4'b1001);
        waitGnt("t4a", 4'b0001, g1);
        busIf.req[0] = 1'b0;
        checkConversion("t4a", 0, 0, 1, 0, d1);
        waitGnt("t4b", 4'b1000, g1);
        busIf.req[3] = 1'b0;
        checkConversion("t4b", 3, 0, 4, 0, d1);

        // Input changed after capture is ignored
        setSlice(1, 8'd128);
        applyStimulus(4'b0010);
        waitGnt("t5", 4'b0010, g1);
        applyStimulus(4'b0000);
        setSlice(1, 8'd7);
        checkConversion("t5", 1, 1, 2, 8, d1);

        // Reset on the edge performing step 4 aborts the conversion
        setSlice(2, 8'd200);
        applyStimulus(4'b0100);
        waitGnt("t6", 4'b0100, g1);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6 abort gnt", 32'(busIf.gnt), 32'd0);
        checkOutput("t6 abort busy", 32'(busIf.busy), 32'd0);
        checkOutput("t6 abort done", 32'(busIf.done), 32'd0);
        checkOutput("t6 abort done_id", 32'(busIf.done_id), 32'd0);
        checkOutput("t6 abort cent", 32'(busIf.cent), 32'd0);
        checkOutput("t6 abort dec", 32'(busIf.dec), 32'd0);
        checkOutput("t6 abort un", 32'(busIf.un), 32'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busIf.done) sawDone = 1'b1;
        end
        checkOutput("t6 no done after abort", 32'(sawDone), 32'd0);
        setSlice(1, 8'd37);
        applyStimulus(4'b0010);
        waitGnt("t6b", 4'b0010, g1);
        applyStimulus(4'b0000);
        checkConversion("t6b", 1, 0, 3, 7, d1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
